// File: rtl/mini_core_rrv_alu_md.sv
// Execute unit for the mini_core_rrv Q101H stage: single-cycle RV32I ALU and branch compare,
// iterative RV32M multiply/divide, valid/ready on both sides, flush on redirect.
module mini_core_rrv_alu_md #(
    parameter int unsigned WIDTH     = 32,
    parameter bit          EN_MULDIV = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [4:0]       op_i,
    input  logic [WIDTH-1:0] in1_i,
    input  logic [WIDTH-1:0] in2_i,
    input  logic             branch_en_i,
    input  logic [2:0]       branch_op_i,
    input  logic [WIDTH-1:0] pc_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             branch_cond_met_o,
    output logic [WIDTH-1:0] result_pc_o,
    output logic             busy_o
);

    localparam int unsigned SW = $clog2(WIDTH);
    localparam int unsigned CW = $clog2(WIDTH);

    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_SLT  = 5'd2;
    localparam logic [4:0] OP_SLTU = 5'd3;
    localparam logic [4:0] OP_SLL  = 5'd4;
    localparam logic [4:0] OP_SRL  = 5'd5;
    localparam logic [4:0] OP_SRA  = 5'd6;
    localparam logic [4:0] OP_XOR  = 5'd7;
    localparam logic [4:0] OP_OR   = 5'd8;
    localparam logic [4:0] OP_AND  = 5'd9;
    localparam logic [4:0] OP_MUL  = 5'd10;
    localparam logic [4:0] OP_REMU = 5'd17;

    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH - 1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [2:0]       sel_q;
    logic             neg_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] pc_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             bcm_q;
    logic [WIDTH-1:0] result_pc_q;
    logic             busy_q;

    logic             accept;
    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] alu_res;
    logic             br_met;

    assign in_ready_o = (state_q == StIdle) && (!out_valid_q || out_ready_i) && !flush_i;
    assign accept     = in_valid_i && in_ready_o;
    assign shamt      = in2_i[SW-1:0];

    assign out_valid_o       = out_valid_q;
    assign result_o          = result_q;
    assign branch_cond_met_o = bcm_q;
    assign result_pc_o       = result_pc_q;
    assign busy_o            = busy_q;

    // Single-cycle ALU; unknown and (when disabled) mul/div opcodes fall back to ADD
    always_comb begin
        alu_res = in1_i + in2_i;
        case (op_i)
            OP_SUB:  alu_res = in1_i - in2_i;
            OP_SLT:  alu_res = {{(WIDTH - 1){1'b0}}, $signed(in1_i) < $signed(in2_i)};
            OP_SLTU: alu_res = {{(WIDTH - 1){1'b0}}, in1_i < in2_i};
            OP_SLL:  alu_res = in1_i << shamt;
            OP_SRL:  alu_res = in1_i >> shamt;
            OP_SRA:  alu_res = $signed(in1_i) >>> shamt;
            OP_XOR:  alu_res = in1_i ^ in2_i;
            OP_OR:   alu_res = in1_i | in2_i;
            OP_AND:  alu_res = in1_i & in2_i;
            default: alu_res = in1_i + in2_i;
        endcase
    end

    // Mul/div decode: operand magnitudes, result sign and the divide corner-case fast path
    logic [2:0]       md_sel;
    logic             is_md;
    logic             sgn1;
    logic             sgn2;
    logic             a_neg;
    logic             b_neg;
    logic             div_zero;
    logic             div_ovf;
    logic             fast;
    logic             neg_start;
    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;
    logic [WIDTH-1:0] fast_res;

    // md_sel: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
    always_comb begin
        md_sel    = 3'(op_i - OP_MUL);
        is_md     = EN_MULDIV && (op_i >= OP_MUL) && (op_i <= OP_REMU);
        sgn1      = md_sel inside {3'd1, 3'd2, 3'd4, 3'd6};
        sgn2      = md_sel inside {3'd1, 3'd4, 3'd6};
        a_neg     = sgn1 && in1_i[WIDTH-1];
        b_neg     = sgn2 && in2_i[WIDTH-1];
        mag1      = a_neg ? -in1_i : in1_i;
        mag2      = b_neg ? -in2_i : in2_i;
        // Remainder follows the dividend; everything else is the xor of operand signs
        neg_start = (md_sel[2] && md_sel[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero  = md_sel[2] && (in2_i == '0);
        div_ovf   = sgn2 && md_sel[2] && (in1_i == MIN_NEG) && (in2_i == ALL_ONES);
        fast      = div_zero || div_ovf;
        if (div_zero) begin
            fast_res = md_sel[1] ? in1_i : ALL_ONES;
        end else begin
            fast_res = md_sel[1] ? '0 : in1_i;
        end
    end

    // Branch compare, evaluated on the offered operands; never set for mul/div ops
    always_comb begin
        br_met = 1'b0;
        if (branch_en_i && !is_md) begin
            case (branch_op_i)
                3'd0:    br_met = (in1_i == in2_i);
                3'd1:    br_met = (in1_i != in2_i);
                3'd4:    br_met = $signed(in1_i) < $signed(in2_i);
                3'd5:    br_met = $signed(in1_i) >= $signed(in2_i);
                3'd6:    br_met = in1_i < in2_i;
                3'd7:    br_met = in1_i >= in2_i;
                default: br_met = 1'b0;
            endcase
        end
    end

    // One iteration: shift-add multiply (hi:lo = partial product:multiplier) or restoring
    // divide (hi:lo = remainder:dividend/quotient)
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shl;
    logic [WIDTH-1:0] hi_nx;
    logic [WIDTH-1:0] lo_nx;

    always_comb begin
        sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        shl = {hi_q, lo_q[WIDTH-1]};
        if (!sel_q[2]) begin
            hi_nx = sum[WIDTH:1];
            lo_nx = {sum[0], lo_q[WIDTH-1:1]};
        end else if (shl >= {1'b0, b_q}) begin
            hi_nx = shl[WIDTH-1:0] - b_q;
            lo_nx = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
            hi_nx = shl[WIDTH-1:0];
            lo_nx = {lo_q[WIDTH-2:0], 1'b0};
        end
    end

    // Final sign fix-up and half / quotient / remainder selection
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   fix_res;

    always_comb begin
        prod_s = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        if (!sel_q[2]) begin
            fix_res = (sel_q == 3'd0) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
        end else if (sel_q[1]) begin
            fix_res = neg_q ? -hi_q : hi_q;
        end else begin
            fix_res = neg_q ? -lo_q : lo_q;
        end
    end

    // Control FSM, iteration datapath and registered output stage
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            sel_q       <= '0;
            neg_q       <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            b_q         <= '0;
            pc_q        <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            bcm_q       <= 1'b0;
            result_pc_q <= '0;
            busy_q      <= 1'b0;
        end else if (flush_i) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (out_valid_q && out_ready_i) begin
                        out_valid_q <= 1'b0;
                    end
                    if (accept) begin
                        if (is_md && !fast) begin
                            state_q <= StCalc;
                            busy_q  <= 1'b1;
                            cnt_q   <= '0;
                            sel_q   <= md_sel;
                            neg_q   <= neg_start;
                            hi_q    <= '0;
                            lo_q    <= mag1;
                            b_q     <= mag2;
                            pc_q    <= pc_i;
                        end else begin
                            out_valid_q <= 1'b1;
                            result_q    <= is_md ? fast_res : alu_res;
                            bcm_q       <= br_met;
                            result_pc_q <= pc_i;
                        end
                    end
                end
                StCalc: begin
                    hi_q  <= hi_nx;
                    lo_q  <= lo_nx;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    // Output stage was drained at accept, so it is free to overwrite here
                    out_valid_q <= 1'b1;
                    result_q    <= fix_res;
                    bcm_q       <= 1'b0;
                    result_pc_q <= pc_q;
                    busy_q      <= 1'b0;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
